// File: rtl/adder_share_sched.sv
// adder_share_sched: one registered WIDTH-bit adder shared by NREQ requesters.
// A round-robin arbiter picks one valid requester per cycle whenever the
// single-entry response slot is empty or being drained in the same cycle.
// The sum, carry and requester id are registered into that slot.
module adder_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry,
  output logic                    busy,
  output logic [15:0]             grant_cnt
);

  if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_param_chk
    $error("adder_share_sched: NREQ must be 2..8 and IDW must equal $clog2(NREQ)");
  end

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;

  logic               gnt_any;
  logic [IDW-1:0]     gnt_idx;
  logic               free;
  logic               grant;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH:0]     sum_full;

  // Round-robin search: iterate from the far end so the lowest offset from ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Slot can accept when empty, or when its current result leaves this cycle.
  assign free  = (state_q == S_EMPTY) || rsp_ready;
  assign grant = free && gnt_any && !rst;

  // One-hot accept toward the winning requester only.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign op_a     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
  assign op_b     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

  // Next-state: a grant refills the slot (even while draining); otherwise a drain empties it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (grant) begin
      state_d = S_FULL;
      ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      cnt_d   = cnt_q + 16'd1;
      id_d    = gnt_idx;
      sum_d   = sum_full[WIDTH-1:0];
      carry_d = sum_full[WIDTH];
    end else if (rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  // ---- stage boundary: response slot register ----
  // Slot, pointer and counter registers; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign busy      = rsp_valid;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: reference model of the arbitration rules
// feeding a response scoreboard, plus directed and random stimulus.
module tb_adder_share_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic                  busy;
  logic [15:0]           grant_cnt;

  adder_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } rsp_t;

  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: is a result outstanding, where the search starts, accepts so far.
  bit          m_full = 1'b0;
  int          m_ptr  = 0;
  logic [15:0] m_cnt  = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decide who should be accepted this cycle and what it must produce.
  always @(negedge clk) begin
    logic [NREQ-1:0]  exp_rdy;
    int               g;
    int               j;
    int               s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    rsp_t             r;
    chk("rsp_valid", rsp_valid, m_full);
    chk("busy", busy, m_full);
    chk("grant_cnt", grant_cnt, m_cnt);
    exp_rdy = '0;
    g = -1;
    if (!rst && (!m_full || rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (rst) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = 16'd0;
      sb.delete();
    end else if (g >= 0) begin
      a = req_a[g*WIDTH +: WIDTH];
      b = req_b[g*WIDTH +: WIDTH];
      s = int'(a) + int'(b);
      r.id    = IDW'(g);
      r.sum   = WIDTH'(s % 65536);
      r.carry = (s >= 65536);
      sb.push_back(r);
      m_ptr  = (g + 1) % NREQ;
      m_cnt  = m_cnt + 16'd1;
      m_full = 1'b1;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
  end

  // Monitor: every presented response must match the oldest expected one; pop when consumed.
  always @(negedge clk) begin
    rsp_t act;
    if (!rst && rsp_valid) begin
      act.id = rsp_id; act.carry = rsp_carry; act.sum = rsp_sum;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", act, 32'hDEAD_BEEF);
      end else begin
        chk("rsp_data", act, sb[0]);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[i]             = v;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    logic [NREQ-1:0] acc;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Single request from requester 2.
    set_req(2, 1'b1, 16'h0003, 16'h0004);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    tick();
    set_req(2, 1'b0, '0, '0);
    @(negedge clk);
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_id", rsp_id, 2);
    chk("single_sum", {rsp_carry, rsp_sum}, 17'h00007);
    chk("single_cnt", grant_cnt, 1);
    tick();

    // Fairness with all requesters continuously valid.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, WIDTH'(i), 16'h0010);
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      chk("fair_valid", rsp_valid, 1'b1);
      chk("fair_id", rsp_id, k % NREQ);
      chk("fair_sum", rsp_sum, 16'h0010 + (k % NREQ));
    end
    tick();
    clear_all();
    tick();

    // Backpressure with requesters 1 and 3, then reset while id 3 is pending.
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(1, 1'b1, 16'h0100, 16'h0023);
    set_req(3, 1'b1, 16'h0300, 16'h0045);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_first_grant", req_ready, 4'b0010);
    tick();
    set_req(1, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_no_grant", req_ready, 4'b0000);
      chk("bp_hold", {rsp_id, rsp_carry, rsp_sum}, {2'd1, 1'b0, 16'h0123});
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", req_ready, 4'b1000);
    tick();
    set_req(3, 1'b1, 16'h0333, 16'h0001);
    set_req(1, 1'b1, 16'h0111, 16'h0002);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_id3", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd3, 16'h0345});
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_cnt", grant_cnt, 0);
    chk("rst_regrant", req_ready, 4'b0010);
    tick();
    set_req(1, 1'b0, '0, '0);
    @(negedge clk);
    chk("rst_id1", {rsp_id, rsp_sum}, {2'd1, 16'h0113});
    tick();
    set_req(3, 1'b0, '0, '0);
    tick();

    // Carry-out corner cases.
    set_req(0, 1'b1, 16'hFFFF, 16'h0001);
    tick();
    set_req(0, 1'b0, '0, '0);
    @(negedge clk);
    chk("wrap_ffff", {rsp_carry, rsp_sum}, 17'h10000);
    tick();
    set_req(2, 1'b1, 16'h8000, 16'h8000);
    tick();
    set_req(2, 1'b0, '0, '0);
    @(negedge clk);
    chk("wrap_8000", {rsp_carry, rsp_sum}, 17'h10000);
    tick();

    // Random traffic with random backpressure; requests held until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) != 0) set_req(i, 1'b1, rnd_op(), rnd_op());
          else set_req(i, 1'b0, '0, '0);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    clear_all();
    rsp_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    tick();

    // Accept counter wrap after 65536 accepts.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rnd_op(), rnd_op());
    rsp_ready = 1'b1;
    repeat (65535) tick();
    @(negedge clk);
    chk("cnt_ffff", grant_cnt, 16'hFFFF);
    tick();
    clear_all();
    @(negedge clk);
    chk("cnt_wrap", grant_cnt, 16'h0000);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Time-multiplexes one registered WIDTH-bit adder (sum = A + B) among NREQ independent requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin scheduler grants one requester per cycle.
- Results return on a single tagged response channel with backpressure.
- Sits between the testbench/stimulus masters and the shared add datapath; replaces per-requester adders.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/sum width in bits.
- IDW, 2, requester-id width; must be $clog2(NREQ) and is checked at elaboration.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester request valid; bit i belongs to requester i.
- req_a  input  NREQ*WIDTH  operand A; slice [i*WIDTH +: WIDTH] belongs to requester i.
- req_b  input  NREQ*WIDTH  operand B; same slicing as req_a.
- req_ready  output  NREQ  one-hot grant/accept; combinational from state and req_valid.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that produced this result.
- rsp_sum  output  WIDTH  (A + B) mod 2^WIDTH.
- rsp_carry  output  1  carry-out of A + B.
- busy  output  1  equals rsp_valid.
- grant_cnt  output  16  total accepted requests; wraps at 0xFFFF -> 0x0000.

Behaviour:
- Reset is sampled on a clk rising edge while rst=1. It forces:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0, grant_cnt=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 for the whole cycle rst is high.
- Output-slot state machine has two states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- free is defined as (EMPTY) or (FULL and rsp_ready=1). The same-cycle drain-and-refill allows one result per clock.
- Arbitration, combinational and evaluated each cycle:
  - If free=1 and any req_valid=1, grant g = the first i with req_valid[i]=1, searching from ptr upward modulo NREQ.
  - req_ready[g]=1; all other bits are 0.
  - If free=0 or rst=1, req_ready is all zero.
- A transfer on requester i is req_valid[i] and req_ready[i] in the same cycle. At the following edge:
  - {rsp_carry, rsp_sum} <= req_a_i + req_b_i, computed at WIDTH+1 bits.
  - rsp_id <= i; rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
  - grant_cnt <= grant_cnt+1.
- Latency: a request accepted in cycle N has its response visible in cycle N+1.
- Response drains at the edge where rsp_valid=1 and rsp_ready=1. If no new grant happens in that cycle, the state becomes EMPTY.
- While FULL and rsp_ready=0:
  - rsp_id, rsp_sum and rsp_carry hold stable.
  - No grants are issued.
  - ptr is unchanged.
- Requesters must hold req_valid, req_a and req_b stable until accepted. The block never drops or reorders a held request.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NREQ-1,0,... with one grant per cycle.
- ptr changes only on a grant. Idle cycles do not advance it.
- Reset mid-operation: a pending response is discarded, not delivered. Requests that were not accepted stay pending at their requesters and are arbitrated from ptr=0 after reset.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Single request: rst 2 cycles; requester 2 presents A=0x0003, B=0x0004, rsp_ready=1. Required: req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_sum=0x0007, rsp_carry=0; grant_cnt=1.
- Fairness: all 4 valid continuously, requester i presents A=i, B=0x10, rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0 on consecutive cycles; sums 0x10,0x11,0x12,0x13; no bubbles.
- Backpressure: rsp_ready=0 for 5 cycles with requesters 1 and 3 valid. Required: one response (id 1) held stable and req_ready=0 for all 5 cycles. When rsp_ready rises, id 3 is granted in that same cycle and its response appears the next cycle.
- Wrap-around: A=0xFFFF, B=0x0001. Required: rsp_sum=0x0000, rsp_carry=1. Separately, A=0x8000, B=0x8000 gives sum 0x0000, carry 1.
- Reset mid-operation: FULL with id 3 pending and ptr=0, rst pulsed 1 cycle. Required: rsp_valid=0 and grant_cnt=0 the cycle after. With requesters 1 and 3 still valid, the next grant is id 1 (ptr=0).
- Counter wrap: force 65536 accepts. Required: grant_cnt reads 0x0000 after the 65536th accept.
